// File: rtl/pc_pkg.sv
// Shared widths, FSM state type and reset address for the fetch PC unit.
// Pure declarations; no logic.
package pc_pkg;

    localparam int PC_W = 32;
    localparam int JT_W = 28;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC candidates: sequential, jump and branch targets plus jump misalignment.
// Purely combinational, zero latency; no flow control.
module pc_next_calc
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [JT_W-1:0] i_jump_target28,
    input  logic [15:0]     i_branch_off,
    output logic [PC_W-1:0] o_pc_plus4,
    output logic [PC_W-1:0] o_jump_tgt,
    output logic [PC_W-1:0] o_branch_tgt,
    output logic            o_jt_misaligned
);

    logic [PC_W-1:0] w_branch_disp;

    assign o_pc_plus4 = i_pc + 32'd4;

    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign o_jump_tgt = {o_pc_plus4[PC_W-1:JT_W], i_jump_target28[JT_W-1:2], 2'b00};

    assign w_branch_disp   = {{14{i_branch_off[15]}}, i_branch_off, 2'b00};
    assign o_branch_tgt    = o_pc_plus4 + w_branch_disp;
    assign o_jt_misaligned = |i_jump_target28[1:0];

endmodule

// File: rtl/pc_jump_unit.sv
// Fetch PC sequencer (IDLE/RUN/HALTED) with jump, branch and halt handling.
// Control sampled on an edge shows on pc at that edge; stall freezes all state.
module pc_jump_unit
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            jump,
    input  logic [JT_W-1:0] jump_target28,
    input  logic            branch,
    input  logic            zero,
    input  logic [15:0]     branch_off,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            valid,
    output logic            redirect,
    output logic            err
);

    pc_state_e       r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_redirect;
    logic            r_err;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_jump_tgt;
    logic [PC_W-1:0] w_branch_tgt;
    logic            w_jt_misaligned;

    pc_next_calc u_next (
        .i_pc            (r_pc),
        .i_jump_target28 (jump_target28),
        .i_branch_off    (branch_off),
        .o_pc_plus4      (w_pc_plus4),
        .o_jump_tgt      (w_jump_tgt),
        .o_branch_tgt    (w_branch_tgt),
        .o_jt_misaligned (w_jt_misaligned)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_err      <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                IDLE: begin
                    r_pc       <= RESET_PC;
                    r_redirect <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        r_state    <= HALTED;
                        r_redirect <= 1'b0;
                    end else if (jump) begin
                        r_pc       <= w_jump_tgt;
                        r_redirect <= 1'b1;
                        if (w_jt_misaligned) begin
                            r_err <= 1'b1;
                        end
                    end else if (branch && zero) begin
                        r_pc       <= w_branch_tgt;
                        r_redirect <= 1'b1;
                    end else begin
                        r_pc       <= w_pc_plus4;
                        r_redirect <= 1'b0;
                    end
                end
                HALTED: begin
                    r_redirect <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign valid    = (r_state == RUN);
    assign redirect = r_redirect;
    assign err      = r_err;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed and random checks of pc_jump_unit (default and near-wrap reset PC)
// against a behavioural model of the fetch sequencer.
module tb_pc_jump_unit;

    logic        clk;
    logic        reset;
    logic        start, stall, jump, branch, zero, halt;
    logic [27:0] jump_target28;
    logic [15:0] branch_off;

    logic [31:0] pc_a, pc4_a, pc_w, pc4_w;
    logic        valid_a, redir_a, err_a, valid_w, redir_w, err_w;

    int vectors;
    int miscompares;

    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam logic [31:0] RPC_W = 32'hFFFF_FFF8;

    // Model: state 0 = idle, 1 = run, 2 = halted.
    int          m_state [2];
    logic [31:0] m_pc    [2];
    logic        m_redir [2];
    logic        m_err   [2];

    pc_jump_unit u_dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .jump(jump),
        .jump_target28(jump_target28), .branch(branch), .zero(zero),
        .branch_off(branch_off), .halt(halt), .pc(pc_a), .pc_plus4(pc4_a),
        .valid(valid_a), .redirect(redir_a), .err(err_a)
    );

    pc_jump_unit #(.RESET_PC(RPC_W)) u_dut_w (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .jump(jump),
        .jump_target28(jump_target28), .branch(branch), .zero(zero),
        .branch_off(branch_off), .halt(halt), .pc(pc_w), .pc_plus4(pc4_w),
        .valid(valid_w), .redirect(redir_w), .err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_pc[k]    = (k == 0) ? RPC_A : RPC_W;
            m_redir[k] = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic model_step();
        int          disp;
        logic [31:0] seq;
        if (stall) return;
        disp = int'($signed(branch_off)) * 4;
        for (int k = 0; k < 2; k++) begin
            seq = m_pc[k] + 32'd4;
            m_redir[k] = 1'b0;
            if (m_state[k] == 0) begin
                if (start) m_state[k] = 1;
            end else if (m_state[k] == 2) begin
                if (start) m_state[k] = 1;
            end else if (halt) begin
                m_state[k] = 2;
            end else if (jump) begin
                m_pc[k]    = (seq & 32'hF000_0000) | ({4'h0, jump_target28} & 32'h0FFF_FFFC);
                m_redir[k] = 1'b1;
                if ((jump_target28 % 4) != 0) m_err[k] = 1'b1;
            end else if (branch && zero) begin
                m_pc[k]    = seq + 32'(disp);
                m_redir[k] = 1'b1;
            end else begin
                m_pc[k] = seq;
            end
        end
    endtask

    task automatic check_all();
        chk("pc_a",    pc_a,           m_pc[0]);
        chk("pc4_a",   pc4_a,          m_pc[0] + 32'd4);
        chk("valid_a", {31'd0, valid_a}, {31'd0, m_state[0] == 1});
        chk("redir_a", {31'd0, redir_a}, {31'd0, m_redir[0]});
        chk("err_a",   {31'd0, err_a},   {31'd0, m_err[0]});
        chk("pc_w",    pc_w,           m_pc[1]);
        chk("pc4_w",   pc4_w,          m_pc[1] + 32'd4);
        chk("valid_w", {31'd0, valid_w}, {31'd0, m_state[1] == 1});
        chk("redir_w", {31'd0, redir_w}, {31'd0, m_redir[1]});
        chk("err_w",   {31'd0, err_w},   {31'd0, m_err[1]});
    endtask

    task automatic drive(input logic s_start, input logic s_stall, input logic s_jump,
                         input logic [27:0] s_jt, input logic s_branch, input logic s_zero,
                         input logic [15:0] s_off, input logic s_halt);
        start = s_start; stall = s_stall; jump = s_jump; jump_target28 = s_jt;
        branch = s_branch; zero = s_zero; branch_off = s_off; halt = s_halt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Called 1 time unit after a rising edge; the pulse ends before the next falling edge.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(0, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        model_reset();
        @(posedge clk); #1;
        do_reset();
        chk("rst_pc_a", pc_a, 32'h0);
        chk("rst_pc_w", pc_w, 32'hFFFF_FFF8);

        // Control inputs in IDLE do nothing.
        drive(0, 0, 1, 28'h0000_040, 1, 1, 16'h0004, 1);
        tick();
        chk("idle_valid", {31'd0, valid_a}, 32'd0);

        // Start, then three sequential RUN cycles; near-wrap instance crosses zero.
        drive(1, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        chk("start_pc", pc_a, 32'h0);
        chk("start_valid", {31'd0, valid_a}, 32'd1);
        drive(0, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        chk("seq1", pc_a, 32'h4);
        chk("wrap1", pc_w, 32'hFFFF_FFFC);
        tick();
        chk("seq2", pc_a, 32'h8);
        chk("wrap2", pc_w, 32'h0000_0000);
        chk("wrap_noerr", {31'd0, err_w}, 32'd0);
        tick();
        chk("seq3", pc_a, 32'hC);

        // Reach 0x1000_0008 across the 256 MB boundary, then region-relative jump.
        drive(0, 0, 1, 28'hFFF_FFF8, 0, 0, 16'h0, 0);
        tick();
        drive(0, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_jump_pc", pc_a, 32'h1000_0008);
        drive(0, 0, 1, 28'h0ABC_DE0, 0, 0, 16'h0, 0);
        tick();
        chk("jump_pc", pc_a, 32'h10AB_CDE0);
        chk("jump_redir", {31'd0, redir_a}, 32'd1);
        chk("jump_err", {31'd0, err_a}, 32'd0);
        drive(0, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        chk("jump_redir_drop", {31'd0, redir_a}, 32'd0);

        // Branch taken backwards and not taken.
        do_reset();
        drive(1, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        drive(0, 0, 1, 28'h000_0100, 0, 0, 16'h0, 0);
        tick();
        chk("br_setup", pc_a, 32'h100);
        drive(0, 0, 0, 28'h0, 1, 1, 16'hFFFE, 0);
        tick();
        chk("br_taken_pc", pc_a, 32'h0000_00FC);
        chk("br_taken_redir", {31'd0, redir_a}, 32'd1);
        drive(0, 0, 1, 28'h000_0100, 0, 0, 16'h0, 0);
        tick();
        drive(0, 0, 0, 28'h0, 1, 0, 16'hFFFE, 0);
        tick();
        chk("br_nt_pc", pc_a, 32'h0000_0104);
        chk("br_nt_redir", {31'd0, redir_a}, 32'd0);

        // Stall over jump+halt, then halt wins; HALTED ignores jump; start resumes.
        drive(0, 1, 1, 28'h000_0400, 1, 1, 16'h0010, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_a, 32'h104);
            chk("stall_valid", {31'd0, valid_a}, 32'd1);
        end
        drive(0, 0, 1, 28'h000_0400, 1, 1, 16'h0010, 1);
        tick();
        chk("halt_valid", {31'd0, valid_a}, 32'd0);
        chk("halt_pc", pc_a, 32'h104);
        drive(0, 0, 1, 28'h000_0400, 0, 0, 16'h0, 0);
        tick();
        chk("halted_nojump", pc_a, 32'h104);
        drive(1, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        chk("resume_valid", {31'd0, valid_a}, 32'd1);
        drive(0, 0, 0, 28'h0, 0, 0, 16'h0, 0);
        tick();
        chk("resume_pc", pc_a, 32'h108);

        // Misaligned jump sets sticky err until reset (mid-run reset on both instances).
        drive(0, 0, 1, 28'h000_0013, 0, 0, 16'h0, 0);
        tick();
        chk("mis_pc", pc_a, 32'h0000_0010);
        chk("mis_err", {31'd0, err_a}, 32'd1);
        drive(0, 0, 1, 28'h000_0200, 0, 0, 16'h0, 0);
        tick();
        chk("err_sticky", {31'd0, err_a}, 32'd1);
        do_reset();
        chk("err_cleared", {31'd0, err_a}, 32'd0);
        chk("midrun_rst_w", pc_w, 32'hFFFF_FFF8);

        // Random phase.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, 28'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 19) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
